// File: rtl/vga_pixel_writer.sv
// Clips the drawer's pixel stream to the screen, buffers linear framebuffer
// writes in a small FWFT FIFO and reports frame completion once drained.
module vga_pixel_writer #(
  parameter int unsigned SCREEN_W = 160,
  parameter int unsigned SCREEN_H = 120,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned ADDR_W   = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        in_x,
  input  logic [6:0]        in_y,
  input  logic [2:0]        in_colour,
  input  logic              in_plot,
  input  logic              in_done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [2:0]        mem_data,
  output logic              mem_we,
  input  logic              mem_ready,
  output logic              frame_done,
  output logic              overflow,
  output logic [15:0]       plot_count,
  output logic [15:0]       drop_count
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned COL_W = 3;

  typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN, DONE} state_t;

  state_t state, state_next;

  logic [ADDR_W-1:0] addr_q   [DEPTH];
  logic [COL_W-1:0]  colour_q [DEPTH];
  logic [CNT_W-1:0]  count;

  logic              on_screen_c;
  logic              pop_c;
  logic              full_c;
  logic              push_c;
  logic              lose_c;
  logic              drop_c;
  logic              new_frame_c;
  logic [ADDR_W-1:0] in_addr_c;
  logic [CNT_W-1:0]  count_next_c;
  logic [CNT_W-1:0]  wr_idx_c;
  logic [15:0]       plot_base_c;
  logic [15:0]       drop_base_c;

  // Head of the shift-register FIFO is always entry 0, so it holds while stalled.
  assign mem_addr = addr_q[0];
  assign mem_data = colour_q[0];

  always_comb begin
    on_screen_c  = (32'(in_x) < SCREEN_W) && (32'(in_y) < SCREEN_H);
    in_addr_c    = ADDR_W'(32'(in_y) * SCREEN_W + 32'(in_x));
    pop_c        = mem_we && mem_ready;
    full_c       = (count == CNT_W'(DEPTH));
    push_c       = in_plot && on_screen_c && (!full_c || pop_c);
    lose_c       = in_plot && on_screen_c && full_c && !pop_c;
    drop_c       = in_plot && !push_c;
    new_frame_c  = (state == IDLE) && in_plot;
    count_next_c = count + CNT_W'(push_c) - CNT_W'(pop_c);
    wr_idx_c     = pop_c ? count - CNT_W'(1) : count;
    plot_base_c  = new_frame_c ? 16'h0000 : plot_count;
    drop_base_c  = new_frame_c ? 16'h0000 : drop_count;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (in_plot)      state_next = ACTIVE;
        else if (in_done) state_next = DONE;
      end
      ACTIVE: begin
        if (in_done) state_next = DRAIN;
      end
      DRAIN: begin
        if ((count == CNT_W'(0)) && !push_c) state_next = DONE;
      end
      DONE: begin
        if (in_plot)       state_next = DRAIN;
        else if (!in_done) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i]   <= '0;
        colour_q[i] <= '0;
      end
      count      <= '0;
      mem_we     <= 1'b0;
      frame_done <= 1'b0;
      overflow   <= 1'b0;
      plot_count <= 16'h0000;
      drop_count <= 16'h0000;
    end else begin
      if (pop_c) begin
        for (int i = 0; i < DEPTH - 1; i++) begin
          addr_q[i]   <= addr_q[i+1];
          colour_q[i] <= colour_q[i+1];
        end
      end
      // A push lands one slot lower when the head leaves in the same cycle.
      for (int i = 0; i < DEPTH; i++) begin
        if (push_c && (wr_idx_c == CNT_W'(i))) begin
          addr_q[i]   <= in_addr_c;
          colour_q[i] <= in_colour;
        end
      end
      count      <= count_next_c;
      mem_we     <= (count_next_c != CNT_W'(0));
      frame_done <= (state_next == DONE);
      overflow   <= (overflow && !new_frame_c) || lose_c;
      if (pop_c && (plot_base_c != 16'hFFFF)) plot_count <= plot_base_c + 16'h0001;
      else                                    plot_count <= plot_base_c;
      if (drop_c && (drop_base_c != 16'hFFFF)) drop_count <= drop_base_c + 16'h0001;
      else                                     drop_count <= drop_base_c;
    end
  end

endmodule

// File: tb/tb_vga_pixel_writer.sv
// Randomized and directed bench for vga_pixel_writer: a queue-based reference
// model predicts writes and counters; a negedge monitor scores every write.
module tb_vga_pixel_writer;

  localparam int unsigned DEPTH = 8;

  logic        clk, rst;
  logic [7:0]  in_x;
  logic [6:0]  in_y;
  logic [2:0]  in_colour;
  logic        in_plot, in_done, mem_ready;
  logic [14:0] mem_addr;
  logic [2:0]  mem_data;
  logic        mem_we, frame_done, overflow;
  logic [15:0] plot_count, drop_count;

  vga_pixel_writer dut (
    .clk(clk), .rst(rst), .in_x(in_x), .in_y(in_y), .in_colour(in_colour),
    .in_plot(in_plot), .in_done(in_done), .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_we(mem_we), .mem_ready(mem_ready), .frame_done(frame_done),
    .overflow(overflow), .plot_count(plot_count), .drop_count(drop_count)
  );

  typedef struct {int addr; int colour;} pix_t;

  pix_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: frame phase 0=idle 1=drawing 2=draining 3=done.
  int m_phase, m_plot, m_drop;
  bit m_ovf;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every accepted write must match the oldest expected pixel.
  always @(negedge clk) begin
    if (!rst && mem_we && mem_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write_addr", int'(mem_addr), -1);
      end else begin
        chk("write_addr", int'(mem_addr), exp_q[0].addr);
        chk("write_data", int'(mem_data), exp_q[0].colour);
        void'(exp_q.pop_front());
      end
    end
  end

  function automatic int sat(input int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  task automatic check_state();
    chk("mem_we", int'(mem_we), int'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      chk("head_addr", int'(mem_addr), exp_q[0].addr);
      chk("head_data", int'(mem_data), exp_q[0].colour);
    end
    chk("plot_count", int'(plot_count), m_plot);
    chk("drop_count", int'(drop_count), m_drop);
    chk("overflow", int'(overflow), int'(m_ovf));
    chk("frame_done", int'(frame_done), int'(m_phase == 3));
  endtask

  task automatic cycle(input bit p, input int x, input int y, input int c,
                       input bit d, input bit r);
    int sz;
    bit on, pop, push;
    in_plot = p; in_x = 8'(x); in_y = 7'(y); in_colour = 3'(c);
    in_done = d; mem_ready = r;
    sz   = exp_q.size();
    on   = p && (x < 160) && (y < 120);
    pop  = (sz > 0) && r;
    push = on && ((sz < DEPTH) || pop);
    if (m_phase == 0 && p) begin
      m_plot = 0; m_drop = 0; m_ovf = 1'b0;
    end
    if (push) exp_q.push_back('{addr: y * 160 + x, colour: c});
    if (pop) m_plot = sat(m_plot + 1);
    if (p && !push) m_drop = sat(m_drop + 1);
    if (on && !push) m_ovf = 1'b1;
    case (m_phase)
      0: if (p) m_phase = 1; else if (d) m_phase = 3;
      1: if (d) m_phase = 2;
      2: if (sz == 0 && !push) m_phase = 3;
      default: if (p) m_phase = 2; else if (!d) m_phase = 0;
    endcase
    @(posedge clk);
    #1;
    check_state();
  endtask

  task automatic idle(input int n, input bit d, input bit r);
    for (int i = 0; i < n; i++) cycle(1'b0, 0, 0, 0, d, r);
  endtask

  task automatic do_reset();
    rst = 1'b1; in_plot = 1'b0; in_done = 1'b0; mem_ready = 1'b0;
    in_x = '0; in_y = '0; in_colour = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    m_phase = 0; m_plot = 0; m_drop = 0; m_ovf = 1'b0;
    chk("rst_mem_we", int'(mem_we), 0);
    chk("rst_mem_addr", int'(mem_addr), 0);
    chk("rst_mem_data", int'(mem_data), 0);
    check_state();
  endtask

  // Close the current frame: hold done until the model reports done, then release.
  task automatic finish_frame();
    int guard = 0;
    while (m_phase != 3 && guard < 200) begin
      cycle(1'b0, 0, 0, 0, 1'b1, 1'($urandom_range(0, 1)));
      guard++;
    end
    chk("frame_close_timeout", int'(m_phase == 3), 1);
    cycle(1'b0, 0, 0, 0, 1'b0, 1'b1);
  endtask

  initial begin
    do_reset();

    // done with no pixels goes straight to done, counters kept
    cycle(1'b0, 0, 0, 0, 1'b1, 1'b1);
    chk("empty_frame_done", int'(frame_done), 1);
    cycle(1'b0, 0, 0, 0, 1'b0, 1'b1);

    // corner pixel
    cycle(1'b1, 159, 119, 5, 1'b0, 1'b1);
    chk("corner_addr", int'(mem_addr), 19199);
    chk("corner_data", int'(mem_data), 5);
    idle(1, 1'b0, 1'b1);
    chk("corner_plot_count", int'(plot_count), 1);

    // off-screen pixels
    cycle(1'b1, 160, 0, 1, 1'b0, 1'b1);
    cycle(1'b1, 0, 120, 2, 1'b0, 1'b1);
    chk("clip_drop_count", int'(drop_count), 2);
    chk("clip_no_write", int'(mem_we), 0);
    finish_frame();

    // overflow: 9 pixels into 8 slots while stalled
    for (int i = 0; i < 9; i++) cycle(1'b1, i, 0, i, 1'b0, 1'b0);
    chk("ovf_flag", int'(overflow), 1);
    chk("ovf_drop_count", int'(drop_count), 1);
    idle(3, 1'b0, 1'b0);
    chk("stall_addr", int'(mem_addr), 0);
    idle(10, 1'b0, 1'b1);
    chk("ovf_plot_count", int'(plot_count), 8);
    finish_frame();

    // full FIFO with simultaneous push and pop
    for (int i = 0; i < 8; i++) cycle(1'b1, i + 10, 3, 7 - i, 1'b0, 1'b0);
    cycle(1'b1, 50, 50, 6, 1'b0, 1'b1);
    chk("full_pushpop_ovf", int'(overflow), 0);
    idle(12, 1'b0, 1'b1);
    chk("full_pushpop_count", int'(plot_count), 9);
    finish_frame();

    // three pixels, done with toggling ready
    cycle(1'b1, 1, 1, 1, 1'b0, 1'b0);
    cycle(1'b1, 2, 2, 2, 1'b0, 1'b0);
    cycle(1'b1, 3, 3, 3, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) cycle(1'b0, 0, 0, 0, 1'b1, 1'(i % 2 == 0));
    chk("toggle_frame_done", int'(frame_done), 1);
    // re-plot from done goes back to draining
    cycle(1'b1, 4, 4, 4, 1'b1, 1'b1);
    chk("replot_frame_done", int'(frame_done), 0);
    idle(3, 1'b1, 1'b1);
    cycle(1'b0, 0, 0, 0, 1'b0, 1'b1);
    cycle(1'b1, 9, 9, 1, 1'b0, 1'b0);
    chk("new_frame_plot_clear", int'(plot_count), 0);
    chk("new_frame_drop_clear", int'(drop_count), 0);
    idle(2, 1'b0, 1'b1);
    finish_frame();

    // random frames
    for (int f = 0; f < 8; f++) begin
      for (int n = 0; n < 40; n++)
        cycle(1'($urandom_range(0, 2) != 0), $urandom_range(0, 175),
              $urandom_range(0, 127), $urandom_range(0, 7), 1'b0,
              1'($urandom_range(0, 3) != 0));
      for (int n = 0; n < 6; n++)
        cycle(1'($urandom_range(0, 3) == 0), $urandom_range(0, 175),
              $urandom_range(0, 127), $urandom_range(0, 7), 1'b1,
              1'($urandom_range(0, 1)));
      finish_frame();
    end

    // reset while draining five buffered pixels
    for (int i = 0; i < 5; i++) cycle(1'b1, 20 + i, 7, i, 1'b0, 1'b0);
    cycle(1'b0, 0, 0, 0, 1'b1, 1'b0);
    do_reset();
    chk("mid_rst_plot_count", int'(plot_count), 0);
    idle(6, 1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
